// File: rtl/cdma_img_fifo_128x11_pkg.sv
// Shared sizing and helpers for the 128x11 image FIFO.
package cdma_img_fifo_128x11_pkg;

  localparam int DEPTH  = 128;
  localparam int WIDTH  = 11;
  localparam int ADDR_W = 7;
  localparam int CNT_W  = 8;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [WIDTH-1:0]  data_t;

  localparam cnt_t FULL_CNT = 8'd128;

  // Occupancy update: +1 on push, -1 on pop, unchanged when both or neither.
  function automatic cnt_t cnt_update(input cnt_t cnt, input logic inc, input logic dec);
    return cnt + {{(CNT_W-1){1'b0}}, inc} - {{(CNT_W-1){1'b0}}, dec};
  endfunction

  // 7-bit address increment wraps 127 -> 0 naturally.
  function automatic addr_t addr_inc(input addr_t adr);
    return adr + {{(ADDR_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/cdma_img_fifo_128x11_ram.sv
// 128x11 RAM with one write port, a registered array read and an output register.
module ram_128x11
  import cdma_img_fifo_128x11_pkg::*;
(
  input  logic              clk,
  input  logic [31:0]       pwrbus_ram_pd,
  input  logic [ADDR_W-1:0] wa,
  input  logic              we,
  input  logic [WIDTH-1:0]  di,
  input  logic [ADDR_W-1:0] ra,
  input  logic              re,
  input  logic              ore,
  output logic [WIDTH-1:0]  dout
);

  data_t mem_r [DEPTH];
  data_t ram_q_r;
  data_t dout_r;
  logic  unused_pd_s;

  // Power-down bus has no functional effect in this model.
  assign unused_pd_s = ^pwrbus_ram_pd;

  // Array write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[wa] <= di;
    end
  end

  // First read stage: array read register.
  always_ff @(posedge clk) begin
    if (re) begin
      ram_q_r <= mem_r[ra];
    end
  end

  // Second read stage: output register, loaded only on a read pop.
  always_ff @(posedge clk) begin
    if (ore) begin
      dout_r <= ram_q_r;
    end
  end

  assign dout = dout_r;

endmodule

// File: rtl/cdma_img_fifo_128x11.sv
// 128x11 FIFO: registered input stage, RAM storage, two-stage read pipeline
// with independent write-side and read-side occupancy counts.
module cdma_img_fifo_128x11
  import cdma_img_fifo_128x11_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_req,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_req,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  input  logic [31:0]      pwrbus_ram_pd
);

  logic  wr_req_in_r;
  data_t wr_data_in_r;
  logic  wr_busy_in_r;
  logic  wr_full_r;
  cnt_t  wr_count_r;
  addr_t wr_adr_r;
  logic  wr_popping_r;

  logic  rd_pushing_r;
  cnt_t  rd_count_r;
  addr_t rd_adr_r;
  logic  rd_req_p_r;
  logic  rd_req_int_r;

  logic  wr_accept_s;
  logic  wr_reserving_s;
  cnt_t  wr_count_next_s;
  logic  wr_full_next_s;
  logic  wr_req_in_next_s;
  logic  wr_busy_in_next_s;

  logic  rd_popping_s;
  cnt_t  rd_count_next_s;
  logic  rd_req_p_next_s;
  logic  rd_req_int_next_s;
  addr_t rd_ra_s;

  // Write side: input beat goes to RAM unless full; hold flag predicts next-cycle stall.
  always_comb begin
    wr_accept_s       = wr_req & ~wr_busy_in_r;
    wr_reserving_s    = wr_req_in_r & ~wr_full_r;
    wr_count_next_s   = cnt_update(wr_count_r, wr_reserving_s, wr_popping_r);
    wr_full_next_s    = (wr_count_next_s == FULL_CNT);
    wr_req_in_next_s  = wr_accept_s | (wr_req_in_r & ~wr_reserving_s);
    wr_busy_in_next_s = wr_req_in_next_s & wr_full_next_s;
  end

  // Write-side state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_req_in_r  <= 1'b0;
      wr_busy_in_r <= 1'b0;
      wr_full_r    <= 1'b0;
      wr_count_r   <= 8'd0;
      wr_adr_r     <= 7'd0;
      wr_popping_r <= 1'b0;
    end else begin
      wr_req_in_r  <= wr_req_in_next_s;
      wr_busy_in_r <= wr_busy_in_next_s;
      wr_full_r    <= wr_full_next_s;
      wr_count_r   <= wr_count_next_s;
      wr_adr_r     <= wr_reserving_s ? addr_inc(wr_adr_r) : wr_adr_r;
      wr_popping_r <= rd_popping_s;
    end
  end

  // Input payload register; frozen while the input beat is held.
  always_ff @(posedge clk) begin
    if (wr_accept_s) begin
      wr_data_in_r <= wr_data;
    end
  end

  // Read side: the array stage is refilled from the next address when the output takes a pop.
  always_comb begin
    rd_popping_s      = rd_req_p_r & (~rd_req_int_r | rd_ready);
    rd_count_next_s   = cnt_update(rd_count_r, rd_pushing_r, rd_popping_s);
    rd_req_p_next_s   = (rd_count_next_s != 8'd0);
    rd_req_int_next_s = rd_popping_s | (rd_req_int_r & ~rd_ready);
    if (rd_popping_s) begin
      rd_ra_s = addr_inc(rd_adr_r);
    end else begin
      rd_ra_s = rd_adr_r;
    end
  end

  // Read-side state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pushing_r <= 1'b0;
      rd_count_r   <= 8'd0;
      rd_adr_r     <= 7'd0;
      rd_req_p_r   <= 1'b0;
      rd_req_int_r <= 1'b0;
    end else begin
      rd_pushing_r <= wr_reserving_s;
      rd_count_r   <= rd_count_next_s;
      rd_adr_r     <= rd_ra_s;
      rd_req_p_r   <= rd_req_p_next_s;
      rd_req_int_r <= rd_req_int_next_s;
    end
  end

  ram_128x11 u_ram (
    .clk           (clk),
    .pwrbus_ram_pd (pwrbus_ram_pd),
    .wa            (wr_adr_r),
    .we            (wr_reserving_s),
    .di            (wr_data_in_r),
    .ra            (rd_ra_s),
    .re            (rd_req_p_next_s),
    .ore           (rd_popping_s),
    .dout          (rd_data)
  );

  assign wr_ready = ~wr_busy_in_r;
  assign rd_req   = rd_req_int_r;

endmodule

// File: tb/tb_cdma_img_fifo_128x11.sv
// Self-checking bench for cdma_img_fifo_128x11: directed steps plus random traffic
// against a queue-based reference model.
module tb_cdma_img_fifo_128x11;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_req;
  logic        wr_ready;
  logic [10:0] wr_data;
  logic        rd_req;
  logic        rd_ready;
  logic [10:0] rd_data;
  logic [31:0] pwrbus_ram_pd;

  int checks = 0;
  int errors = 0;

  logic [10:0] model_q[$];
  logic        hold_prev;
  logic [10:0] hold_data;
  logic [10:0] exp_data;

  int val, pops, first, last, stalls, full_seen, idle_req, pw, pr, phase;

  always #5 clk = ~clk;

  cdma_img_fifo_128x11 dut (
    .clk           (clk),
    .reset         (reset),
    .wr_req        (wr_req),
    .wr_ready      (wr_ready),
    .wr_data       (wr_data),
    .rd_req        (rd_req),
    .rd_ready      (rd_ready),
    .rd_data       (rd_data),
    .pwrbus_ram_pd (pwrbus_ram_pd)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset         = 1'b1;
    wr_req        = 1'b0;
    wr_data       = 11'd0;
    rd_ready      = 1'b0;
    pwrbus_ram_pd = 32'd0;
    hold_prev     = 1'b0;
    hold_data     = 11'd0;

    // Reference model: every accepted beat must emerge once, in order; held output must not change.
    fork
      forever begin
        @(negedge clk);
        if (reset) begin
          model_q.delete();
          hold_prev = 1'b0;
        end else begin
          if (hold_prev) begin
            check("hold_rd_req", 32'(rd_req), 32'd1);
            check("hold_rd_data", 32'(rd_data), 32'(hold_data));
          end
          if (wr_req && wr_ready) model_q.push_back(wr_data);
          if (rd_req && rd_ready) begin
            if (model_q.size() == 0) begin
              check("unexpected_beat_q_size", 32'(model_q.size()), 32'd1);
            end else begin
              exp_data = model_q.pop_front();
              check("rd_data_order", 32'(rd_data), 32'(exp_data));
            end
          end
          hold_prev = rd_req && !rd_ready;
          hold_data = rd_data;
        end
      end
    join_none

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_wr_ready", 32'(wr_ready), 32'd1);
    check("reset_rd_req", 32'(rd_req), 32'd0);

    // Single beat latency: accepted in cycle 0, visible in cycle 4, gone in cycle 5.
    next_cycle();
    wr_req   = 1'b1;
    wr_data  = 11'h155;
    rd_ready = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      check($sformatf("latency_rd_req_c%0d", c), 32'(rd_req), (c == 4) ? 32'd1 : 32'd0);
      if (c == 4) check("latency_rd_data", 32'(rd_data), 32'h155);
      next_cycle();
      wr_req = 1'b0;
    end

    // Fill with the reader stalled: 128 in RAM, one in the output register, one held at the input.
    rd_ready = 1'b0;
    val = 0;
    for (int c = 0; c < 200; c++) begin
      wr_req  = (val < 200);
      wr_data = 11'(val);
      @(negedge clk);
      if (wr_req && wr_ready) val++;
      next_cycle();
    end
    check("fill_accepted", 32'(val), 32'd130);
    check("fill_wr_ready", 32'(wr_ready), 32'd0);
    check("fill_rd_req", 32'(rd_req), 32'd1);
    check("fill_head_data", 32'(rd_data), 32'd0);
    rd_ready = 1'b1;
    for (int c = 0; c < 2000 && (val < 200 || model_q.size() != 0); c++) begin
      wr_req  = (val < 200);
      wr_data = 11'(val);
      @(negedge clk);
      if (wr_req && wr_ready) val++;
      next_cycle();
    end
    wr_req = 1'b0;
    check("fill_all_written", 32'(val), 32'd200);
    check("fill_drained", 32'(model_q.size()), 32'd0);
    repeat (6) next_cycle();
    check("fill_idle_rd_req", 32'(rd_req), 32'd0);

    // Streaming with a random power-down bus: one beat per cycle after 4-cycle latency.
    rd_ready = 1'b1;
    first = -1; last = -1; pops = 0; stalls = 0;
    for (int c = 0; c < 1010; c++) begin
      wr_req        = (c < 1000);
      wr_data       = 11'($urandom);
      pwrbus_ram_pd = $urandom;
      @(negedge clk);
      if (wr_req && !wr_ready) stalls++;
      if (rd_req && rd_ready) begin
        if (first < 0) first = c;
        last = c;
        pops++;
      end
      next_cycle();
    end
    wr_req = 1'b0;
    check("stream_pops", 32'(pops), 32'd1000);
    check("stream_first_pop", 32'(first), 32'd4);
    check("stream_last_pop", 32'(last), 32'd1003);
    check("stream_wr_stalls", 32'(stalls), 32'd0);
    check("stream_drained", 32'(model_q.size()), 32'd0);

    // Random traffic in phases that push the FIFO to full and back to empty.
    full_seen = 0;
    for (int c = 0; c < 10000; c++) begin
      phase = (c / 500) % 3;
      pw = (phase == 0) ? 90 : (phase == 1) ? 30 : 60;
      pr = (phase == 0) ? 20 : (phase == 1) ? 90 : 60;
      wr_req        = ($urandom_range(0, 99) < pw);
      rd_ready      = ($urandom_range(0, 99) < pr);
      wr_data       = 11'($urandom);
      pwrbus_ram_pd = $urandom;
      @(negedge clk);
      if (!wr_ready) full_seen++;
      next_cycle();
    end
    wr_req   = 1'b0;
    rd_ready = 1'b1;
    for (int c = 0; c < 400 && model_q.size() != 0; c++) next_cycle();
    check("random_full_reached", 32'(full_seen != 0), 32'd1);
    check("random_drained", 32'(model_q.size()), 32'd0);

    // Reset mid-operation discards 50 stored beats.
    rd_ready = 1'b0;
    for (int c = 0; c < 50; c++) begin
      wr_req  = 1'b1;
      wr_data = 11'($urandom);
      next_cycle();
    end
    wr_req = 1'b0;
    reset  = 1'b1;
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("midreset_wr_ready", 32'(wr_ready), 32'd1);
    check("midreset_rd_req", 32'(rd_req), 32'd0);
    rd_ready = 1'b1;
    idle_req = 0;
    for (int c = 0; c < 10; c++) begin
      next_cycle();
      @(negedge clk);
      if (rd_req) idle_req++;
    end
    check("midreset_no_old_data", 32'(idle_req), 32'd0);
    next_cycle();
    for (int c = 0; c < 20; c++) begin
      wr_req  = 1'b1;
      wr_data = 11'h400 + 11'(c);
      next_cycle();
    end
    wr_req = 1'b0;
    for (int c = 0; c < 100 && model_q.size() != 0; c++) next_cycle();
    check("midreset_new_drained", 32'(model_q.size()), 32'd0);
    repeat (6) next_cycle();
    check("midreset_final_rd_req", 32'(rd_req), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdma_img_fifo_128x11.md
CDMA_IMG_FIFO_128X11 -- requirements
Module: cdma_img_fifo_128x11

Interface
REQ-001 The module SHALL have exactly one clock and one reset: reset is synchronous and active-high.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 wr_req  input  1  write valid.
REQ-005 wr_ready  output  1  write ready; a beat transfers when wr_req && wr_ready.
REQ-006 wr_data  input  11  write payload.
REQ-007 rd_req  output  1  read valid.
REQ-008 rd_ready  input  1  read ready; a beat transfers when rd_req && rd_ready.
REQ-009 rd_data  output  11  read payload, valid while rd_req=1.
REQ-010 pwrbus_ram_pd  input  32  RAM power-down control, forwarded to the RAM only, no functional effect.

Function
REQ-011 Strict FIFO order, no loss, no duplication; storage is a 128x11 RAM plus pipeline registers.
REQ-012 Input stage: an accepted beat is registered (wr_req_in/wr_data_in); it is written to RAM the next cycle if the write side is not full, else held until space exists.
REQ-013 wr_ready SHALL be the registered inverse of "input held"; once deasserted, wr_data_in is held stable and no new beat is accepted.
REQ-014 Write-side count (0..128) increments on RAM write, decrements one cycle after each read pop; full when count would reach 128.
REQ-015 Write address and read address are 7-bit and wrap 127->0.
REQ-016 Read side learns of a RAM write one cycle later (rd_pushing) and keeps its own count.
REQ-017 RAM read is two-stage: re with address (next address when popping) loads the array read; ore (=read pop) loads the RAM output register that drives rd_data.
REQ-018 Latency: wr_req accepted in cycle 0 into an empty FIFO -> rd_req=1 with that data in cycle 4.
REQ-019 rd_req SHALL stay asserted and rd_data stable while rd_ready=0 (no drop, no change).
REQ-020 Sustained throughput SHALL be one beat per cycle on both sides when not full/empty and rd_ready=1.
REQ-021 Simultaneous push and pop SHALL leave counts unchanged.
REQ-022 Read of an address written in the same cycle SHALL never be used; output data is taken only via the pop path.
REQ-023 No programmable write limit; the full threshold is fixed at 128.

Reset
REQ-024 Reset SHALL clear wr_req_in, input-hold flag, full flag, both counts, both addresses, rd_pushing, wr_popping, rd_req_p, rd_req_int.
REQ-025 After reset: wr_ready=1, rd_req=0; RAM contents and data registers are not reset.
REQ-026 Reset asserted mid-operation SHALL discard all stored beats; the FIFO is empty on the first cycle after reset is released.

Structure
REQ-027 A shared package SHALL hold DEPTH=128, WIDTH=11, ADDR_W=7, CNT_W=8.
REQ-028 One sub-module ram_128x11 SHALL be used: write port (wa, we, di), read port (ra, re), output register enable ore, dout, pwrbus_ram_pd.
REQ-029 Clock gating, if used, SHALL be functionally transparent; an ungated implementation is compliant.

Verification
REQ-030 Reset, then single write 0x155 at cycle 0 with rd_ready=1 -> rd_req=1, rd_data=0x155 at cycle 4, rd_req=0 at cycle 5.
REQ-031 Write 0..199 continuously with rd_ready=0 -> wr_ready drops after 128 beats in RAM plus the held input beat; then rd_ready=1 -> all accepted values read in order 0,1,2,...
REQ-032 Stream 1000 beats with rd_ready=1 -> after initial latency one beat per cycle, addresses wrap, data matches in order.
REQ-033 Random wr_req/rd_ready toggling for 10k cycles -> scoreboard order match; rd_data stable whenever rd_req=1 and rd_ready=0.
REQ-034 Fill 50 beats, assert reset one cycle -> wr_ready=1, rd_req=0, and no old data ever emerges afterwards.
REQ-035 Toggle pwrbus_ram_pd randomly during REQ-032 traffic -> identical results.
